// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: gathers/scatters LANES memory words to/from one vector register.
// Define VEC_MEM_STRIDE_EN to step addresses by the stride latched at start (default: unit stride).
module vec_mem_seq #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [4:0]              vreg,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  output logic                    busy,
  output logic                    done,
  output logic [4:0]              v_rs1,
  input  logic [LANES*ELEM_W-1:0] v_read_data,
  output logic [4:0]              v_rd,
  output logic [LANES*ELEM_W-1:0] v_writedata,
  output logic                    v_regwrite,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [ELEM_W-1:0]       mem_rdata
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_WAIT, S_LD_WB, S_ST_RD0, S_ST_RD1, S_ST_REQ, S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [4:0]                     vreg_q;
  logic [LANES-1:0][ELEM_W-1:0]   vbuf_q;
  logic [ADDR_W-1:0]              step;

`ifdef VEC_MEM_STRIDE_EN
  logic [ADDR_W-1:0] step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      step_q <= stride;
    end
  end

  assign step = step_q;
`else
  logic unused_stride;

  assign unused_stride = ^stride;
  assign step          = ADDR_W'(ELEM_W / 8);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = is_store ? S_ST_RD0 : S_LD_REQ;
      S_LD_REQ:  if (mem_ready) state_d = S_LD_WAIT;
      S_LD_WAIT: if (mem_rvalid) state_d = (idx_q == LAST_IDX) ? S_LD_WB : S_LD_REQ;
      S_LD_WB:   state_d = S_DONE;
      S_ST_RD0:  state_d = S_ST_RD1;
      S_ST_RD1:  state_d = S_ST_REQ;
      S_ST_REQ:  if (mem_ready && idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Lane index, address, register index and vector buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      addr_q <= '0;
      vreg_q <= '0;
      vbuf_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            vreg_q <= vreg;
            addr_q <= base_addr;
            idx_q  <= '0;
          end
        end
        S_LD_WAIT: begin
          if (mem_rvalid) begin
            vbuf_q[idx_q] <= mem_rdata;
            if (idx_q != LAST_IDX) begin
              idx_q  <= idx_q + IDX_W'(1);
              addr_q <= addr_q + step;
            end
          end
        end
        S_ST_RD1: vbuf_q <= v_read_data;
        S_ST_REQ: begin
          if (mem_ready && idx_q != LAST_IDX) begin
            idx_q  <= idx_q + IDX_W'(1);
            addr_q <= addr_q + step;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode; everything is zero outside the state that drives it
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    v_rs1       = '0;
    v_rd        = '0;
    v_writedata = '0;
    v_regwrite  = 1'b0;
    unique case (state_q)
      S_LD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      S_LD_WB: begin
        v_regwrite  = 1'b1;
        v_rd        = vreg_q;
        v_writedata = vbuf_q;
      end
      S_ST_RD0, S_ST_RD1: v_rs1 = vreg_q;
      S_ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = vbuf_q[idx_q];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Scoreboard bench for vec_mem_seq: memory/register-file responders, reference model, monitor.
// Honours VEC_MEM_STRIDE_EN the same way as the design.
module tb_vec_mem_seq;

  localparam int unsigned LANES  = 8;
  localparam int unsigned ELEM_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned VEC_W  = LANES * ELEM_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic [4:0]        vreg = '0;
  logic [31:0]       base_addr = '0;
  logic [31:0]       stride = '0;
  logic              busy, done, v_regwrite, mem_req, mem_we;
  logic [4:0]        v_rs1, v_rd;
  logic [VEC_W-1:0]  v_read_data, v_writedata;
  logic [31:0]       mem_addr, mem_wdata;
  logic              mem_ready, mem_rvalid;
  logic [31:0]       mem_rdata;

  vec_mem_seq #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .vreg(vreg),
    .base_addr(base_addr), .stride(stride), .busy(busy), .done(done), .v_rs1(v_rs1),
    .v_read_data(v_read_data), .v_rd(v_rd), .v_writedata(v_writedata),
    .v_regwrite(v_regwrite), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]       rd;
    logic [VEC_W-1:0] data;
  } wr_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  int   exp_done[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;

  logic [31:0]      env_mem [logic [31:0]];
  logic [31:0]      ref_mem [logic [31:0]];
  logic [VEC_W-1:0] env_regs [32];
  logic [VEC_W-1:0] ref_regs [32];

  int               ready_wait = 0;
  int               rv_delay = 0;
  int               wait_left = 0;
  bit               rv_pending = 0;
  int               rv_cnt = 0;
  logic [31:0]      rv_data = '0;
  logic [VEC_W-1:0] rd_pipe = '0;

  bit   prev_stall = 0;
  bit   prev_done = 0;
  req_t prev_r;

  task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mem_dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return mem_dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_dflt(a);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory and register-file responder, driven on the falling edge
  initial begin
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    v_read_data = '0;
    forever begin
      @(negedge clk);
      v_read_data = rd_pipe;
      rd_pipe     = env_regs[v_rs1];
      if (v_regwrite) env_regs[v_rd] = v_writedata;
      if (reset) rv_pending = 0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
          rv_pending = 0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_req) begin
        mem_rvalid = 1'($urandom_range(0, 1));
      end
      if (mem_req) begin
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          wait_left = ready_wait;
          if (mem_we) begin
            env_mem[mem_addr] = mem_wdata;
          end else begin
            rv_pending = 1;
            rv_cnt     = rv_delay;
            rv_data    = env_rd(mem_addr);
          end
        end else begin
          mem_ready = 1'b0;
          wait_left--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        wait_left = ready_wait;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request, a write or done
  initial forever begin
    req_t e;
    wr_t  w;
    int   d;
    @(negedge clk);
    #1;
    if (reset) begin
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      if (prev_done) begin
        chk("busy_after_done", VEC_W'(busy), '0);
        chk("done_one_cycle", VEC_W'(done), '0);
      end
      if (prev_stall && mem_req) begin
        chk("stall_we", VEC_W'(mem_we), VEC_W'(prev_r.we));
        chk("stall_addr", VEC_W'(mem_addr), VEC_W'(prev_r.addr));
        chk("stall_wdata", VEC_W'(mem_wdata), VEC_W'(prev_r.wdata));
      end
      if (mem_req && mem_ready) begin
        if (exp_req.size() == 0) begin
          fail_evt("extra_mem_req");
        end else begin
          e = exp_req.pop_front();
          chk("req_we", VEC_W'(mem_we), VEC_W'(e.we));
          chk("req_addr", VEC_W'(mem_addr), VEC_W'(e.addr));
          if (e.we) chk("req_wdata", VEC_W'(mem_wdata), VEC_W'(e.wdata));
        end
      end
      if (v_regwrite) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          fail_evt("extra_regwrite");
        end else begin
          w = exp_wr.pop_front();
          chk("wr_rd", VEC_W'(v_rd), VEC_W'(w.rd));
          chk("wr_data", v_writedata, w.data);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          fail_evt("extra_done");
        end else begin
          d = exp_done.pop_front();
          if (d >= 0) chk("done_cycle", VEC_W'(cyc), VEC_W'(d));
        end
      end
      prev_stall = mem_req && !mem_ready;
      prev_r     = '{mem_we, mem_addr, mem_wdata};
      prev_done  = done;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, VEC_W'(busy), '0);
    chk({tag, "_done"}, VEC_W'(done), '0);
    chk({tag, "_mem_req"}, VEC_W'(mem_req), '0);
    chk({tag, "_mem_we"}, VEC_W'(mem_we), '0);
    chk({tag, "_mem_addr"}, VEC_W'(mem_addr), '0);
    chk({tag, "_mem_wdata"}, VEC_W'(mem_wdata), '0);
    chk({tag, "_v_rs1"}, VEC_W'(v_rs1), '0);
    chk({tag, "_v_rd"}, VEC_W'(v_rd), '0);
    chk({tag, "_v_writedata"}, v_writedata, '0);
    chk({tag, "_v_regwrite"}, VEC_W'(v_regwrite), '0);
  endtask

  function automatic logic [31:0] step_of(input logic [31:0] strd);
`ifdef VEC_MEM_STRIDE_EN
    return strd;
`else
    return 32'(strd & 32'h0) + 32'd4;
`endif
  endfunction

  task automatic recover();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_req.delete();
    exp_wr.delete();
    exp_done.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Issue one operation: model its effect, push expectations, then drive and wait for done
  task automatic do_op(input bit st, input logic [4:0] vr, input logic [31:0] base,
                       input logic [31:0] strd, input int rw, input int rdly, input bit junk);
    logic [VEC_W-1:0] v;
    logic [31:0]      a;
    bit               got;
    int               s;
    int               t;
    @(negedge clk);
    ready_wait = rw;
    rv_delay   = rdly;
    @(negedge clk);
    s = cyc + 1;
    v = ref_regs[vr];
    for (int k = 0; k < int'(LANES); k++) begin
      a = base + 32'(k) * step_of(strd);
      if (st) begin
        exp_req.push_back('{1'b1, a, v[32*k +: 32]});
        ref_mem[a] = v[32*k +: 32];
      end else begin
        v[32*k +: 32] = ref_rd(a);
        exp_req.push_back('{1'b0, a, 32'h0});
      end
    end
    if (!st) begin
      exp_wr.push_back('{vr, v});
      ref_regs[vr] = v;
    end
    exp_done.push_back((rw == 0 && rdly == 0) ? s + (st ? 10 : 17) : -1);
    start     = 1'b1;
    is_store  = st;
    vreg      = vr;
    base_addr = base;
    stride    = strd;
    @(negedge clk);
    chk("busy_rise", VEC_W'(busy), VEC_W'(1));
    base_addr = $urandom;
    stride    = $urandom;
    vreg      = 5'($urandom);
    is_store  = 1'($urandom);
    got = 0;
    t   = 0;
    while (!got && t < 3000) begin
      if (done) got = 1;
      start = junk && busy && (done || $urandom_range(0, 3) == 0);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (!got) begin
      fail_evt("done_timeout");
      recover();
    end
  endtask

  // Abort a load with reset while it waits for lane 4's data
  task automatic reset_mid_load();
    int s;
    int w0;
    @(negedge clk);
    ready_wait = 0;
    rv_delay   = 0;
    @(negedge clk);
    s = cyc + 1;
    for (int k = 0; k < 5; k++) exp_req.push_back('{1'b0, 32'h400 + 32'(4 * k), 32'h0});
    start     = 1'b1;
    is_store  = 1'b0;
    vreg      = 5'd6;
    base_addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 9) @(negedge clk);
    chk("pre_rst_busy", VEC_W'(busy), VEC_W'(1));
    chk("pre_rst_no_req", VEC_W'(mem_req), '0);
    w0    = wr_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_regwrite", VEC_W'(wr_cnt), VEC_W'(w0));
    chk("abort_req_drained", VEC_W'(exp_req.size()), '0);
  endtask

  initial begin
    logic [VEC_W-1:0] rv;
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < int'(LANES); k++) rv[32*k +: 32] = $urandom;
      env_regs[r] = rv;
      ref_regs[r] = rv;
    end
    for (int k = 0; k < int'(LANES); k++) begin
      env_mem[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);
      ref_mem[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);
      rv[32*k +: 32] = 32'h11 * 32'(k + 1);
    end
    env_regs[5] = rv;
    ref_regs[5] = rv;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    do_op(1'b0, 5'd3, 32'h100, 32'h4, 0, 0, 1'b0);
    do_op(1'b1, 5'd5, 32'h200, 32'h4, 0, 0, 1'b0);
    do_op(1'b0, 5'd7, 32'h100, 32'h4, 3, 2, 1'b0);
    reset_mid_load();
    do_op(1'b0, 5'd9, 32'h200, 32'h4, 0, 0, 1'b0);
    do_op(1'b0, 5'd10, 32'hFFFF_FFF8, 32'h4, 0, 0, 1'b0);
    do_op(1'b1, 5'd3, 32'hFFFF_FFF8, 32'h4, 1, 0, 1'b1);
    do_op(1'b0, 5'd11, 32'h0, 32'h40, 0, 0, 1'b1);
    do_op(1'b1, 5'd7, 32'h800, 32'h0, 0, 0, 1'b1);
    do_op(1'b0, 5'd12, 32'h800, 32'h0, 2, 1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] b;
      logic [31:0] sd;
      b  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                       : ($urandom & 32'h0000_0FFC);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hFC);
      do_op(1'($urandom), 5'($urandom_range(0, 7)), b, sd,
            $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end

    repeat (10) @(negedge clk);
    chk("end_req_q", VEC_W'(exp_req.size()), '0);
    chk("end_wr_q", VEC_W'(exp_wr.size()), '0);
    chk("end_done_q", VEC_W'(exp_done.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector load/store sequencer for the vector unit: the client-side master of the vector register file's write and read ports. On a load it gathers LANES 32-bit memory words into one 256-bit vector and writes it to the register file. On a store it reads a 256-bit register and scatters it to memory as LANES sequential 32-bit writes. It sits between the vector issue stage (start/done handshake) and the scalar data-memory port, with at most one memory request outstanding.

## Interface
- LANES, 8, elements per vector; LANES*ELEM_W = 256
- ELEM_W, 32, element / memory word width
- ADDR_W, 32, byte-address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; sampled with start
- vreg  in  5  vector register index; sampled with start
- base_addr  in  ADDR_W  first element byte address; sampled with start
- stride  in  ADDR_W  byte stride; used only with VEC_MEM_STRIDE_EN
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- v_rs1  out  5  register-file read index
- v_read_data  in  256  register-file read data (registered in register file)
- v_rd  out  5  register-file write index
- v_writedata  out  256  register-file write data
- v_regwrite  out  1  register-file write enable
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write request
- mem_addr  out  ADDR_W  request byte address
- mem_wdata  out  ELEM_W  write data
- mem_ready  in  1  request accepted at this edge when mem_req=1
- mem_rvalid  in  1  read data valid
- mem_rdata  in  ELEM_W  read data

## Operation
- Moore FSM: IDLE, LD_REQ, LD_WAIT, LD_WB, ST_RD0, ST_RD1, ST_REQ, DONE. Outputs decode from state and datapath registers.
- IDLE with start=1: latch vreg, base_addr and is_store. Set lane index i=0 and addr=base_addr. Go to LD_REQ (load) or ST_RD0 (store). start while busy is ignored.
- LD_REQ: mem_req=1, mem_we=0, mem_addr=addr. Leave for LD_WAIT on the edge where mem_ready=1; otherwise hold.
- LD_WAIT: on mem_rvalid=1, write mem_rdata into buffer bits [ELEM_W*i+ELEM_W-1 : ELEM_W*i]. If i=LANES-1, go to LD_WB. Otherwise i++, addr+=step, go to LD_REQ.
- LD_WB: v_regwrite=1, v_rd=vreg, v_writedata=buffer for exactly one cycle, then go to DONE.
- ST_RD0/ST_RD1: v_rs1=vreg and v_regwrite=0 for both cycles. These two cycles cover the register file's registered read. Capture v_read_data into the buffer at the end of ST_RD1, then go to ST_REQ.
- ST_REQ: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=buffer lane i. On mem_ready: if i=LANES-1, go to DONE; otherwise i++, addr+=step.
- DONE: done=1 for one cycle, then go to IDLE.
- step = ELEM_W/8, or stride when VEC_MEM_STRIDE_EN is defined. The address adds modulo 2^ADDR_W, so it wraps silently.
- mem_rvalid outside LD_WAIT is ignored. mem_ready while mem_req=0 is ignored.
- v_regwrite is asserted only in LD_WB, so a store never corrupts the register file.

## Timing
- Reset, including mid-operation: state=IDLE, i=0, buffer=0. All outputs are 0: busy, done, mem_req, mem_we, v_regwrite, and all address/data outputs. An aborted load never writes the register file.
- Zero-wait memory (mem_ready=1, mem_rvalid in the cycle after acceptance): 2 cycles per load element.
  - Load: done is high in the 18th cycle after the start edge.
  - Store: done is high in the 11th cycle after the start edge.
- busy rises the cycle after start is sampled and falls in the cycle after done.
- mem_addr, mem_wdata and mem_we are stable while mem_req=1 and mem_ready=0.
- Back-to-back: start asserted during DONE is ignored. start is next accepted in IDLE.

## Configuration
- VEC_MEM_STRIDE_EN defined: the address step is the stride value latched at start. A stride of 0 repeats the same address LANES times.
- VEC_MEM_STRIDE_EN undefined: the step is fixed at ELEM_W/8 (unit stride) and the stride port is ignored.

## Test plan
- Load, vreg=3, base=0x100, memory word at 0x100+4k = 0xA0+k, ready/rvalid always 1 -> eight reads at 0x100..0x11C. Single v_regwrite with v_rd=3 and lane k=0xA0+k. done in cycle 18.
- Store, vreg=5 holding lanes 0x11*(k+1), base=0x200 -> v_rs1=5 for 2 cycles, then eight writes at 0x200..0x21C with data 0x11..0x88. v_regwrite stays 0. done in cycle 11.
- Load with mem_ready low 3 cycles per request and rvalid delayed 2 cycles -> request held stable, the same final vector is written, and exactly one write occurs.
- Reset asserted in LD_WAIT after lane 4 -> next cycle all outputs are 0, no v_regwrite occurs, and a subsequent load completes normally.
- Wrap: base=0xFFFFFFF8, unit stride -> addresses FFFFFFF8, FFFFFFFC, 0, 4, … 0x14.
- VEC_MEM_STRIDE_EN defined, stride=0x40, base=0 -> addresses 0x0, 0x40, … 0x1C0. start pulsed mid-operation -> ignored.
